// File: rtl/mem_lsu_pkg.sv
// Shared execute-stage op codes, LSU state encoding and small decode helpers
// for the load/store unit.
package mem_lsu_pkg;

    localparam logic [7:0] EXE_NOP_OP = 8'h00;
    localparam logic [7:0] EXE_OR_OP  = 8'h25;
    localparam logic [7:0] EXE_ADD_OP = 8'h20;
    localparam logic [7:0] EXE_LB_OP  = 8'hE0;
    localparam logic [7:0] EXE_LH_OP  = 8'hE1;
    localparam logic [7:0] EXE_LW_OP  = 8'hE3;
    localparam logic [7:0] EXE_LBU_OP = 8'hE4;
    localparam logic [7:0] EXE_LHU_OP = 8'hE5;
    localparam logic [7:0] EXE_SB_OP  = 8'hE8;
    localparam logic [7:0] EXE_SH_OP  = 8'hE9;
    localparam logic [7:0] EXE_SW_OP  = 8'hEB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    function automatic logic is_load(input logic [7:0] op);
        return op inside {EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP};
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] off);
        logic half_op;
        logic word_op;
        half_op = op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP};
        word_op = op inside {EXE_LW_OP, EXE_SW_OP};
        return (half_op && off[0]) || (word_op && (off != 2'b00));
    endfunction

    function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] off);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 4'b0001 << off;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return off[1] ? 4'b1100 : 4'b0011;
            EXE_LW_OP, EXE_SW_OP:             return 4'b1111;
            default:                          return 4'b0000;
        endcase
    endfunction

    // Narrow stores replicate their data so the selected lanes always carry it.
    function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] d);
        case (op)
            EXE_SB_OP: return {4{d[7:0]}};
            EXE_SH_OP: return {2{d[15:0]}};
            EXE_SW_OP: return d;
            default:   return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/halfword from a loaded bus word and
// sign- or zero-extends it to 32 bits.
module lsu_load_align
    import mem_lsu_pkg::*;
(
    input  logic [7:0]  op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_w;
    logic [15:0] half_w;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = data_i[8*gi +: 8];
        end
    endgenerate

    assign byte_w = lane[off_i];
    assign half_w = off_i[1] ? data_i[31:16] : data_i[15:0];

    always_comb begin
        data_o = 32'h0;
        case (op_i)
            EXE_LB_OP:  data_o = {{24{byte_w[7]}}, byte_w};
            EXE_LBU_OP: data_o = {24'h0, byte_w};
            EXE_LH_OP:  data_o = {{16{half_w[15]}}, half_w};
            EXE_LHU_OP: data_o = {16'h0, half_w};
            EXE_LW_OP:  data_o = data_i;
            default:    data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory stage load/store unit: stalls the pipeline around a single bus
// transaction with acknowledge timeout, lane steering and load extension.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i,
    output logic        misalign_o,
    output logic        bus_err_o
);

    // The last BUSY cycle allowed is the one where the counter reads ACK_TIMEOUT-1.
    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

    lsu_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  sel_q;
    logic [31:0] sdata_q;
    logic [7:0]  op_q;
    logic [1:0]  off_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        launch;
    logic        timeout;
    logic        mem_op;
    logic        misal;
    logic [31:0] load_val;

    assign mem_op = is_load(aluop_i) || is_store(aluop_i);
    assign misal  = is_misaligned(aluop_i, mem_addr_i[1:0]);

    lsu_load_align u_align (
        .op_i   (op_q),
        .off_i  (off_q),
        .data_i (rdata_q),
        .data_o (load_val)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        launch     = 1'b0;
        timeout    = 1'b0;
        stallreq   = 1'b0;
        misalign_o = 1'b0;
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    wreg_o  = 1'b0;
                    wdata_o = 32'h0;
                    if (misal) begin
                        misalign_o = 1'b1;
                    end else begin
                        stallreq = 1'b1;
                        launch   = 1'b1;
                        cnt_d    = 8'h0;
                        state_d  = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                stallreq = 1'b1;
                wreg_o   = 1'b0;
                wdata_o  = 32'h0;
                // An ack in the timeout cycle still completes normally.
                if (mem_ack_i) begin
                    state_d = ST_DONE;
                end else if (cnt_q == TO_LAST) begin
                    timeout = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                wreg_o  = is_load(op_q) && !err_q && wreg_i;
                wdata_o = load_val;
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst) begin
            stallreq   = 1'b0;
            misalign_o = 1'b0;
            wd_o       = 5'h0;
            wreg_o     = 1'b0;
            wdata_o    = 32'h0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'h0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            sel_q   <= 4'h0;
            sdata_q <= 32'h0;
            op_q    <= 8'h0;
            off_q   <= 2'b00;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= timeout;
            if (launch) begin
                we_q    <= is_store(aluop_i);
                addr_q  <= {mem_addr_i[31:2], 2'b00};
                sel_q   <= lane_sel(aluop_i, mem_addr_i[1:0]);
                sdata_q <= store_data(aluop_i, reg2_i);
                op_q    <= aluop_i;
                off_q   <= mem_addr_i[1:0];
            end
            if (state_q == ST_BUSY && mem_ack_i) begin
                rdata_q <= mem_data_i;
            end
        end
    end

    assign mem_req_o  = (state_q == ST_BUSY);
    assign mem_we_o   = we_q;
    assign mem_addr_o = addr_q;
    assign mem_sel_o  = sel_q;
    assign mem_data_o = sdata_q;
    assign bus_err_o  = err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized scoreboard bench for mem_lsu with a 4-cycle acknowledge timeout.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i = 32'h0;
    logic        mem_ack_i = 1'b0;
    logic        misalign_o;
    logic        bus_err_o;

    mem_lsu #(.ACK_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .stallreq(stallreq), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i), .misalign_o(misalign_o),
        .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr_in;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        bit          chk;
        logic        mis;
        logic        err;
        int          stall;
        int          req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] sdata;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          txn = 0;
    bit          active = 0;
    bit          force_ack = 0;
    int          ack_wait = 0;
    logic [31:0] ack_data = 32'h0;
    int          busy_cnt = 0;
    int          stall_cnt = 0;
    int          req_cnt = 0;
    exp_t        mon_e;
    bit          mon_ok;

    task automatic check(input string name, input bit ok, input string msg);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, msg);
    endtask

    // Expected response derived from the access size, signedness and the ack delay.
    function automatic exp_t model(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                                   input logic [4:0] wd, input logic wr, input logic [31:0] wdat,
                                   input int w, input logic [31:0] d);
        exp_t e;
        int size, off, busy;
        bit sgn, st, mem;
        logic [31:0] mask, v;
        size = 4; sgn = 0; st = 0; mem = 1;
        case (op)
            EXE_LB_OP:  begin size = 1; sgn = 1; end
            EXE_LBU_OP: size = 1;
            EXE_LH_OP:  begin size = 2; sgn = 1; end
            EXE_LHU_OP: size = 2;
            EXE_LW_OP:  size = 4;
            EXE_SB_OP:  begin size = 1; st = 1; end
            EXE_SH_OP:  begin size = 2; st = 1; end
            EXE_SW_OP:  begin size = 4; st = 1; end
            default:    mem = 0;
        endcase
        e.op = op; e.addr_in = addr; e.wd = wd; e.wreg = 0; e.wdata = 0; e.chk = 0;
        e.mis = 0; e.err = 0; e.stall = 0; e.req = 0; e.we = 0; e.addr = 0; e.sel = 0; e.sdata = 0;
        off = int'(addr[1:0]);
        if (!mem) begin
            e.wreg = wr; e.wdata = wdat; e.chk = 1;
        end else if (off % size != 0) begin
            e.mis = 1;
        end else begin
            busy = (w < T) ? w + 1 : T;
            e.err = (w >= T); e.req = busy; e.stall = busy + 1; e.we = st;
            e.addr = addr & ~32'h3;
            for (int k = 0; k < size; k++) e.sel[off + k] = 1'b1;
            for (int i = 0; i < 4; i++) e.sdata[8*i +: 8] = r2[8*(i % size) +: 8];
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
            v = (d >> (8*off)) & mask;
            if (sgn && v[8*size-1]) v = v | ~mask;
            e.chk = !st && !e.err; e.wreg = e.chk && wr; e.wdata = v;
        end
        return e;
    endfunction

    // Bus responder: ack after ack_wait BUSY cycles, stray acks while idle.
    always @(negedge clk) begin
        if (mem_req_o) begin
            mem_ack_i  = (busy_cnt == ack_wait);
            mem_data_i = (busy_cnt == ack_wait) ? ack_data : $urandom();
            busy_cnt++;
        end else begin
            busy_cnt   = 0;
            mem_ack_i  = force_ack || ($urandom_range(0, 3) == 0);
            mem_data_i = $urandom();
        end
    end

    // Monitor: bus fields checked every BUSY cycle, response on the stall-free cycle.
    always @(negedge clk) begin
        if (rst || !active) begin
            stall_cnt = 0; req_cnt = 0;
        end else if (stallreq) begin
            stall_cnt++;
            if (mem_req_o) begin
                req_cnt++;
                if (sb.size() > 0) begin
                    mon_e = sb[0];
                    mon_ok = (mem_addr_o == mon_e.addr) && (mem_sel_o == mon_e.sel) &&
                             (mem_we_o == mon_e.we) && (!mon_e.we || mem_data_o == mon_e.sdata);
                    check("bus_hold", mon_ok, $sformatf("got addr=%08h sel=%b we=%b data=%08h, want addr=%08h sel=%b we=%b data=%08h",
                          mem_addr_o, mem_sel_o, mem_we_o, mem_data_o, mon_e.addr, mon_e.sel, mon_e.we, mon_e.sdata));
                end
            end
        end else if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            mon_ok = (wd_o == mon_e.wd) && (wreg_o == mon_e.wreg) && (misalign_o == mon_e.mis) &&
                     (bus_err_o == mon_e.err) && (!mon_e.chk || wdata_o == mon_e.wdata) && !mem_req_o;
            check("resp", mon_ok, $sformatf("op=%02h addr=%08h got wd=%0d wreg=%b wdata=%08h mis=%b err=%b req=%b, want wd=%0d wreg=%b wdata=%08h mis=%b err=%b req=0",
                  mon_e.op, mon_e.addr_in, wd_o, wreg_o, wdata_o, misalign_o, bus_err_o, mem_req_o,
                  mon_e.wd, mon_e.wreg, mon_e.wdata, mon_e.mis, mon_e.err));
            check("latency", stall_cnt == mon_e.stall && req_cnt == mon_e.req,
                  $sformatf("op=%02h got stall=%0d req=%0d, want stall=%0d req=%0d",
                  mon_e.op, stall_cnt, req_cnt, mon_e.stall, mon_e.req));
            $display("txn %0d op=%02h addr=%08h wdata=%08h wreg=%b mis=%b err=%b stall=%0d",
                     txn, mon_e.op, mon_e.addr_in, wdata_o, wreg_o, misalign_o, bus_err_o, stall_cnt);
            txn++; stall_cnt = 0; req_cnt = 0;
        end
    end

    task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                         input logic [4:0] wd, input logic wr, input logic [31:0] wdat,
                         input int w, input logic [31:0] d);
        int n;
        sb.push_back(model(op, addr, r2, wd, wr, wdat, w, d));
        ack_wait = w; ack_data = d;
        aluop_i = op; mem_addr_i = addr; reg2_i = r2; wd_i = wd; wreg_i = wr; wdata_i = wdat;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stallreq && n < 40);
        if (stallreq) check("retire_timeout", 1'b0, $sformatf("stallreq still 1 after %0d cycles", n));
        @(posedge clk);
        #1;
    endtask

    task automatic random_txn();
        logic [7:0] ops [12];
        ops = '{EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP, EXE_SB_OP,
                EXE_SH_OP, EXE_SW_OP, EXE_NOP_OP, EXE_OR_OP, EXE_ADD_OP, 8'hE2};
        issue(ops[$urandom_range(0, 11)], $urandom(), $urandom(), 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), $urandom(), $urandom_range(0, 5), $urandom());
    endtask

    initial begin
        rst = 1'b1;
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h104; reg2_i = 32'hCAFE_F00D;
        wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", stallreq == 0 && wreg_o == 0 && wd_o == 0 && wdata_o == 0 && misalign_o == 0 &&
              bus_err_o == 0 && mem_req_o == 0 && mem_we_o == 0 && mem_sel_o == 0 && mem_addr_o == 0 && mem_data_o == 0,
              $sformatf("got stall=%b wreg=%b wd=%0d wdata=%08h req=%b sel=%b addr=%08h, want all zero",
              stallreq, wreg_o, wd_o, wdata_o, mem_req_o, mem_sel_o, mem_addr_o));
        aluop_i = EXE_NOP_OP; wreg_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        active = 1;

        issue(EXE_LW_OP,  32'h100, 32'h0, 5'd3, 1'b1, 32'h0, 0, 32'hDEAD_BEEF);
        issue(EXE_LB_OP,  32'h103, 32'h0, 5'd4, 1'b1, 32'h0, 1, 32'h8012_3456);
        issue(EXE_LBU_OP, 32'h103, 32'h0, 5'd5, 1'b1, 32'h0, 2, 32'h8012_3456);
        issue(EXE_LHU_OP, 32'h102, 32'h0, 5'd6, 1'b1, 32'h0, 0, 32'h8012_3456);
        issue(EXE_SH_OP,  32'h202, 32'h1234_ABCD, 5'd8, 1'b1, 32'h0, 3, 32'h0);
        issue(EXE_LW_OP,  32'h101, 32'h0, 5'd9, 1'b1, 32'h0, 0, 32'h0);
        issue(EXE_LW_OP,  32'h400, 32'h0, 5'd10, 1'b1, 32'h0, 255, 32'h0);
        issue(EXE_LH_OP,  32'h402, 32'h0, 5'd11, 1'b1, 32'h0, T - 1, 32'h9ABC_0001);
        issue(EXE_OR_OP,  32'h0, 32'h0, 5'd12, 1'b1, 32'h5A5A_A5A5, 0, 32'h0);
        for (int i = 0; i < 60; i++) random_txn();

        // Reset in the middle of a BUSY cycle, then stray acks while idle.
        active = 0;
        sb.delete();
        ack_wait = 255;
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h300; wd_i = 5'd2; wreg_i = 1'b1;
        @(posedge clk);
        #2;
        check("busy_before_rst", mem_req_o == 1 && stallreq == 1,
              $sformatf("got req=%b stall=%b, want 1 1", mem_req_o, stallreq));
        rst = 1'b1;
        #1;
        check("rst_mid_busy", mem_req_o == 0 && stallreq == 0 && mem_sel_o == 0 && mem_addr_o == 0 &&
              mem_we_o == 0 && wreg_o == 0 && wdata_o == 0 && bus_err_o == 0,
              $sformatf("got req=%b stall=%b sel=%b addr=%08h wreg=%b, want all zero",
              mem_req_o, stallreq, mem_sel_o, mem_addr_o, wreg_o));
        aluop_i = EXE_NOP_OP; wreg_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        force_ack = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ack_ignored", mem_req_o == 0 && stallreq == 0 && bus_err_o == 0 && wreg_o == 0,
                  $sformatf("got req=%b stall=%b err=%b wreg=%b, want 0 0 0 0",
                  mem_req_o, stallreq, bus_err_o, wreg_o));
        end
        force_ack = 0;
        @(posedge clk);
        #1;
        active = 1;
        issue(EXE_LW_OP, 32'h100, 32'h0, 5'd3, 1'b1, 32'h0, 0, 32'hDEAD_BEEF);
        for (int i = 0; i < 10; i++) random_txn();

        check("scoreboard_drained", sb.size() == 0, $sformatf("got %0d pending, want 0", sb.size()));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
